// File: rtl/ber_checker.sv
// ber_checker: symbol-domain BER checker. Searches the tx->rx symbol delay,
// declares lock, then counts bit errors over 2^MEAS_LOG2-symbol periods.
`default_nettype none

module ber_checker #(
    parameter int DEPTH       = 32,
    parameter int WIN         = 64,
    parameter int LOCK_THRESH = 4,
    parameter int LOSS_THRESH = 32,
    parameter int MEAS_LOG2   = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sym_clk_ena,
    input  logic                       clear,
    input  logic [1:0]                 tx_syms_i,
    input  logic [1:0]                 tx_syms_q,
    input  logic [1:0]                 rx_syms_i,
    input  logic [1:0]                 rx_syms_q,
    output logic                       locked,
    output logic [$clog2(DEPTH)-1:0]   delay,
    output logic [MEAS_LOG2+2:0]       bit_errs,
    output logic                       meas_done
);

    localparam int DW  = $clog2(DEPTH);
    localparam int WW  = $clog2(WIN);
    localparam int WAW = $clog2(4 * WIN + 1);
    localparam int MW  = MEAS_LOG2 + 3;

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCK   = 1'b1
    } state_t;

    state_t             state_q;
    logic               locked_q;
    logic [DW-1:0]      delay_q;
    logic [MW-1:0]      bit_errs_q;
    logic               meas_done_q;
    logic [3:0]         hist_q [1:DEPTH-1];
    logic [WW-1:0]      win_cnt_q;
    logic [WAW-1:0]     win_acc_q;
    logic [MEAS_LOG2-1:0] meas_cnt_q;
    logic [MW-1:0]      meas_acc_q;

    logic [3:0]         cur_tx;
    logic [3:0]         cur_rx;
    logic [3:0]         taps [DEPTH];
    logic [3:0]         diff;
    logic [2:0]         sym_err;
    logic [WAW-1:0]     win_sum_d;
    logic [MW-1:0]      meas_sum_d;
    logic               win_end;
    logic               meas_end;

    assign cur_tx = {tx_syms_i, tx_syms_q};
    assign cur_rx = {rx_syms_i, rx_syms_q};

    // Tap k is the tx symbol presented k enables ago; tap 0 is the live input.
    always_comb begin
        taps[0] = cur_tx;
        for (int k = 1; k < DEPTH; k++) begin
            taps[k] = hist_q[k];
        end
    end

    assign diff       = cur_rx ^ taps[delay_q];
    assign sym_err    = 3'(diff[0]) + 3'(diff[1]) + 3'(diff[2]) + 3'(diff[3]);
    assign win_sum_d  = win_acc_q + WAW'(sym_err);
    assign meas_sum_d = meas_acc_q + MW'(sym_err);
    assign win_end    = (win_cnt_q == WW'(WIN - 1));
    assign meas_end   = &meas_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_SEARCH;
            locked_q    <= 1'b0;
            delay_q     <= '0;
            bit_errs_q  <= '0;
            meas_done_q <= 1'b0;
            win_cnt_q   <= '0;
            win_acc_q   <= '0;
            meas_cnt_q  <= '0;
            meas_acc_q  <= '0;
            for (int k = 1; k < DEPTH; k++) begin
                hist_q[k] <= '0;
            end
        end else begin
            meas_done_q <= 1'b0;
            if (clear) begin
                state_q    <= ST_SEARCH;
                locked_q   <= 1'b0;
                delay_q    <= '0;
                bit_errs_q <= '0;
                win_cnt_q  <= '0;
                win_acc_q  <= '0;
                meas_cnt_q <= '0;
                meas_acc_q <= '0;
                for (int k = 1; k < DEPTH; k++) begin
                    hist_q[k] <= '0;
                end
            end else if (sym_clk_ena) begin
                hist_q[1] <= cur_tx;
                for (int k = 2; k < DEPTH; k++) begin
                    hist_q[k] <= hist_q[k-1];
                end

                if (win_end) begin
                    win_cnt_q <= '0;
                    win_acc_q <= '0;
                end else begin
                    win_cnt_q <= win_cnt_q + 1'b1;
                    win_acc_q <= win_sum_d;
                end

                case (state_q)
                    ST_SEARCH: begin
                        if (win_end) begin
                            if (win_sum_d <= WAW'(LOCK_THRESH)) begin
                                state_q    <= ST_LOCK;
                                locked_q   <= 1'b1;
                                meas_cnt_q <= '0;
                                meas_acc_q <= '0;
                            end else begin
                                delay_q <= delay_q + 1'b1;
                            end
                        end
                    end
                    ST_LOCK: begin
                        // Measurement completes even if lock is lost on the same enable.
                        if (meas_end) begin
                            bit_errs_q  <= meas_sum_d;
                            meas_done_q <= 1'b1;
                            meas_cnt_q  <= '0;
                            meas_acc_q  <= '0;
                        end else begin
                            meas_cnt_q <= meas_cnt_q + 1'b1;
                            meas_acc_q <= meas_sum_d;
                        end
                        if (win_end && (win_sum_d > WAW'(LOSS_THRESH))) begin
                            state_q  <= ST_SEARCH;
                            locked_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= ST_SEARCH;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked    = locked_q;
    assign delay     = delay_q;
    assign bit_errs  = bit_errs_q;
    assign meas_done = meas_done_q;

endmodule

`default_nettype wire

// File: tb/tb_ber_checker.sv
// Directed self-checking bench for ber_checker (DEPTH=8, WIN=16, MEAS_LOG2=6).
`default_nettype none

module tb_ber_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sym_clk_ena = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] tx_syms_i = '0, tx_syms_q = '0, rx_syms_i = '0, rx_syms_q = '0;
    logic       locked;
    logic [2:0] delay;
    logic [8:0] bit_errs;
    logic       meas_done;

    int checks = 0;
    int errors = 0;
    int md_cnt = 0;
    int md_base;
    logic [3:0] txh [0:7];

    ber_checker #(
        .DEPTH(8), .WIN(16), .LOCK_THRESH(4), .LOSS_THRESH(32), .MEAS_LOG2(6)
    ) dut (
        .clk(clk), .reset(reset), .sym_clk_ena(sym_clk_ena), .clear(clear),
        .tx_syms_i(tx_syms_i), .tx_syms_q(tx_syms_q),
        .rx_syms_i(rx_syms_i), .rx_syms_q(rx_syms_q),
        .locked(locked), .delay(delay), .bit_errs(bit_errs), .meas_done(meas_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (meas_done === 1'b1) md_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_hist();
        for (int k = 0; k < 8; k++) txh[k] = '0;
    endtask

    // One enable every 4 clks; outputs are stable on return.
    task automatic sym(input logic [3:0] tx, input logic [3:0] rx, input logic clr);
        @(negedge clk);
        {tx_syms_i, tx_syms_q} = tx;
        {rx_syms_i, rx_syms_q} = rx;
        sym_clk_ena = 1'b1;
        clear = clr;
        @(negedge clk);
        sym_clk_ena = 1'b0;
        clear = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic gen(input int dly, input logic [3:0] flip);
        logic [3:0] tx, rx;
        tx = 4'($urandom);
        rx = ((dly == 0) ? tx : txh[dly-1]) ^ flip;
        sym(tx, rx, 1'b0);
        for (int k = 7; k > 0; k--) txh[k] = txh[k-1];
        txh[0] = tx;
    endtask

    task automatic run(input int n, input int dly, input int flip_every, input logic [3:0] flip);
        for (int i = 0; i < n; i++) begin
            gen(dly, (flip_every > 0 && (i % flip_every) == flip_every - 1) ? flip : 4'h0);
        end
    endtask

    task automatic do_clear();
        sym(4'($urandom), 4'($urandom), 1'b1);
        clr_hist();
    endtask

    initial begin
        clr_hist();
        repeat (3) @(negedge clk);
        chk("reset_locked", 32'(locked), 0);
        chk("reset_delay", 32'(delay), 0);
        chk("reset_bit_errs", 32'(bit_errs), 0);
        chk("reset_meas_done", 32'(meas_done), 0);
        reset = 1'b1;

        // Clean link at delay 5: one delay step per failing window, lock at enable 96.
        for (int w = 1; w <= 5; w++) begin
            run(16, 5, 0, 4'h0);
            chk("d5_search_delay", 32'(delay), 32'(w));
            chk("d5_search_locked", 32'(locked), 0);
        end
        run(15, 5, 0, 4'h0);
        chk("d5_pre_lock", 32'(locked), 0);
        run(1, 5, 0, 4'h0);
        chk("d5_lock", 32'(locked), 1);
        chk("d5_lock_delay", 32'(delay), 5);
        md_base = md_cnt;
        run(63, 5, 0, 4'h0);
        chk("d5_no_meas_yet", 32'(md_cnt - md_base), 0);
        run(1, 5, 0, 4'h0);
        chk("d5_meas_pulse", 32'(md_cnt - md_base), 1);
        chk("d5_bit_errs", 32'(bit_errs), 0);

        // Sparse errors: one bit flipped every 8 enables -> 8 per period.
        md_base = md_cnt;
        run(64, 5, 8, 4'h1);
        chk("sparse_bit_errs", 32'(bit_errs), 8);
        chk("sparse_locked", 32'(locked), 1);
        chk("sparse_meas_pulse", 32'(md_cnt - md_base), 1);

        // Loss of lock: every rx bit inverted.
        run(15, 5, 1, 4'hF);
        chk("loss_pre", 32'(locked), 1);
        run(1, 5, 1, 4'hF);
        chk("loss_locked", 32'(locked), 0);
        chk("loss_delay", 32'(delay), 5);
        chk("loss_bit_errs", 32'(bit_errs), 8);

        // Re-lock at delay 5, then clear mid-measurement.
        run(16, 5, 0, 4'h0);
        chk("relock", 32'(locked), 1);
        run(20, 5, 8, 4'h1);
        md_base = md_cnt;
        do_clear();
        chk("clr_locked", 32'(locked), 0);
        chk("clr_delay", 32'(delay), 0);
        chk("clr_bit_errs", 32'(bit_errs), 0);
        chk("clr_meas_pulse", 32'(md_cnt - md_base), 0);
        run(95, 5, 0, 4'h0);
        chk("clr_reacq_pre", 32'(locked), 0);
        chk("clr_reacq_pre_delay", 32'(delay), 5);
        run(1, 5, 0, 4'h0);
        chk("clr_reacq_lock", 32'(locked), 1);
        run(64, 5, 8, 4'h1);
        chk("clr_meas_bit_errs", 32'(bit_errs), 8);

        // Delay 0: lock at enable 16.
        do_clear();
        run(15, 0, 0, 4'h0);
        chk("d0_pre", 32'(locked), 0);
        run(1, 0, 0, 4'h0);
        chk("d0_lock", 32'(locked), 1);
        chk("d0_delay", 32'(delay), 0);

        // No match anywhere: delay wraps 7 -> 0.
        do_clear();
        for (int i = 0; i < 112; i++) sym(4'hF, 4'h0, 1'b0);
        chk("wrap_delay7", 32'(delay), 7);
        for (int i = 0; i < 16; i++) sym(4'hF, 4'h0, 1'b0);
        chk("wrap_delay0", 32'(delay), 0);
        chk("wrap_locked", 32'(locked), 0);

        // Delay 7: lock at enable 128.
        do_clear();
        run(127, 7, 0, 4'h0);
        chk("d7_pre", 32'(locked), 0);
        chk("d7_pre_delay", 32'(delay), 7);
        run(1, 7, 0, 4'h0);
        chk("d7_lock", 32'(locked), 1);
        run(64, 7, 8, 4'h2);
        chk("d7_bit_errs", 32'(bit_errs), 8);
        run(5, 7, 0, 4'h0);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("arst_locked", 32'(locked), 0);
        chk("arst_delay", 32'(delay), 0);
        chk("arst_bit_errs", 32'(bit_errs), 0);
        chk("arst_meas_done", 32'(meas_done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clr_hist();
        run(15, 0, 0, 4'h0);
        chk("arst_reacq_pre", 32'(locked), 0);
        run(1, 0, 0, 4'h0);
        chk("arst_reacq_lock", 32'(locked), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ber_checker.md
# ber_checker

Symbol-domain bit-error-rate checker for the 16-QAM modem. It is the far end of the transmit symbol source: it takes the 2-bit I/Q symbols fed to the transmitter and the 2-bit I/Q decisions produced by the receiver. It finds the end-to-end symbol delay and declares lock, then reports bit-error counts over fixed-length measurement periods. It sits beside the receiver in the modem top level and is clocked on `clk`, qualified by `sym_clk_ena`.

## Interface

- DEPTH, 32: transmit-symbol history length; searchable delay range is 0..DEPTH-1. Must be a power of 2.
- WIN, 64: symbols per search/loss-check window.
- LOCK_THRESH, 4: maximum bit errors in a window for the lock to be declared.
- LOSS_THRESH, 32: bit errors in a window above which the lock is dropped.
- MEAS_LOG2, 20: a measurement period is 2^MEAS_LOG2 symbols.

Ports:

- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- sym_clk_ena  input  1  symbol-rate enable; all state advances only on clk edges where it is 1.
- clear  input  1  synchronous restart, active high.
- tx_syms_i, tx_syms_q  input  2 each  symbols presented to the transmitter.
- rx_syms_i, rx_syms_q  input  2 each  receiver decisions.
- locked  output  1  delay found and the checker is measuring.
- delay  output  log2(DEPTH)  current candidate or locked delay, in symbols.
- bit_errs  output  MEAS_LOG2+3  bit-error count of the last completed measurement.
- meas_done  output  1  one-clk pulse when bit_errs updates.

## Operation

- History: a DEPTH-entry shift register of {tx_i, tx_q}. It shifts on each enable and is zero after reset or clear.
- Reference for delay d: the tx symbol presented d enables earlier. For d=0 this is the current input.
- Per-enable error: the popcount of {rx_i,rx_q} XOR reference, giving 0..4.
- SEARCH state:
  - Accumulate window errors over WIN enables.
  - At the WIN-th enable, the total includes that enable.
  - If the total is ≤ LOCK_THRESH, go to LOCK with delay held.
  - Otherwise set delay to (delay+1) mod DEPTH, giving wrap-around from DEPTH-1 to 0.
  - In both cases the window counter and window accumulator restart.
- LOCK state:
  - Windowing continues as in SEARCH.
  - If a window total is > LOSS_THRESH, go to SEARCH with delay unchanged. The partial measurement is discarded and bit_errs retains its old value.
  - Measurement: the period counter and accumulator are zeroed on entry to LOCK.
  - On the 2^MEAS_LOG2-th enable in LOCK:
    - bit_errs is loaded with the accumulator including that enable's error.
    - meas_done pulses.
    - The accumulator and counter restart without a gap.
- If loss of lock and measurement completion happen on the same enable, both take effect: bit_errs and meas_done update, then the state goes to SEARCH.
- Width: the accumulator has MEAS_LOG2+3 bits. The maximum is 4·2^MEAS_LOG2, so it never overflows.
- clear:
  - It has priority over sym_clk_ena.
  - It forces SEARCH, delay=0, zeroes the history, all counters and bit_errs, and forces locked=0 and meas_done=0.
  - A symbol coinciding with clear is not counted.
- locked=1 exactly when the state is LOCK.

## Timing

- Reset (reset=0): locked=0, delay=0, bit_errs=0, meas_done=0. The state is SEARCH and history and counters are zero. This takes effect immediately, with no clock required.
- All outputs are registered.
- locked, delay and bit_errs change on the clk edge at which the deciding enable is sampled.
- meas_done is high for exactly one clk, directly after that edge, even though enables are sparse.
- The first window starts at the first enable after reset or clear is released.
- Worst-case acquisition: DEPTH·WIN enables.

## Test plan

Use DEPTH=8, WIN=16, LOCK_THRESH=4, LOSS_THRESH=32, MEAS_LOG2=6, and one enable every 4 clks.

- Clean link, delay 5: random tx, with rx = tx delayed by 5 enables → delay steps 0..5, and locked rises at the end of window 6 (enable 96) with delay=5. After 64 more enables, meas_done pulses once and bit_errs=0.
- Delay 0 and wrap: start with rx = tx at delay 0 → lock at enable 16. Separately, use delay 7 → lock at enable 128. With no match at any delay, delay wraps 7→0 and locked stays 0.
- Sparse errors: while locked, flip one rx bit every 8 enables → each measurement reports bit_errs=8 and locked stays 1.
- Loss of lock: while locked, invert all rx bits → locked falls at the end of the current window, delay is unchanged, and bit_errs keeps the last value.
- clear coincident with sym_clk_ena mid-measurement → the next clk shows locked=0, delay=0, bit_errs=0, and that symbol is not counted. Re-acquisition then matches the first scenario.
- Assert reset=0 asynchronously mid-LOCK between clk edges → all outputs are 0 before the next edge. After release, behaviour is the same as from power-up.
